// File: rtl/traffic_phase_ctrl_pkg.sv
// traffic_pkg: controller state encoding and signal-head colour codes.
package traffic_pkg;
    typedef enum logic [1:0] {ALLRED, GREEN, YELLOW, FLASH} state_t;
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;
endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: control inputs and signal-head outputs of one intersection.
interface traffic_phase_ctrl_if #(parameter int NUM_PHASES = 2);
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    logic                    en;
    logic                    flash_mode;
    logic [NUM_PHASES-1:0]   ped_req;
    logic [3*NUM_PHASES-1:0] light;
    logic [NUM_PHASES-1:0]   walk;
    logic [NUM_PHASES-1:0]   ped_pending;
    logic [PW-1:0]           cur_phase;
    logic                    flashing;
    modport master (output en, flash_mode, ped_req,
                    input  light, walk, ped_pending, cur_phase, flashing);
    modport slave  (input  en, flash_mode, ped_req,
                    output light, walk, ped_pending, cur_phase, flashing);
endinterface

// File: rtl/traffic_phase_ctrl_ped_req_latch.sv
// ped_req_latch: sticky pedestrian requests; a serve clear beats a same-cycle request.
module ped_req_latch #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_ignore,
    input  logic [N-1:0] i_clr,
    input  logic         i_clr_all,
    output logic [N-1:0] o_pend
);
    logic [N-1:0] r_pend;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pend <= '0;
        else
            r_pend <= i_clr_all ? '0 : (r_pend | (i_ignore ? '0 : i_req)) & ~i_clr;
    end
    assign o_pend = r_pend;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin N-phase signal controller with all-red clearance,
// pedestrian walk service, early green cut, flashing-yellow maintenance and enable hold.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES  = 2,
    parameter int CNT_W       = 8,
    parameter int GREEN_TIME  = 15,
    parameter int YELLOW_TIME = 5,
    parameter int ALLRED_TIME = 2,
    parameter int MIN_GREEN   = 5,
    parameter int FLASH_HALF  = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    traffic_phase_ctrl_if.slave bus
);
    localparam int PW   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int CMAX = (1 << CNT_W) - 1;
    if (NUM_PHASES < 2 || GREEN_TIME < 1 || YELLOW_TIME < 1 || ALLRED_TIME < 1 ||
        FLASH_HALF < 1 || MIN_GREEN < 1 || MIN_GREEN > GREEN_TIME ||
        GREEN_TIME > CMAX || YELLOW_TIME > CMAX || ALLRED_TIME > CMAX ||
        MIN_GREEN > CMAX || FLASH_HALF > CMAX) begin : g_param_err
        $error("traffic_phase_ctrl: illegal timing parameters");
    end
    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] F_LAST   = CNT_W'(FLASH_HALF - 1);
    localparam logic [PW-1:0]    LAST_PH  = PW'(NUM_PHASES - 1);
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [PW-1:0]         r_phase;
    logic                  r_flash_off;
    logic [NUM_PHASES-1:0] r_walk;
    logic [NUM_PHASES-1:0] w_pend;
    logic [NUM_PHASES-1:0] w_phase_oh;
    logic [NUM_PHASES-1:0] w_nxt_oh;
    logic [PW-1:0]         w_phase_nxt;
    logic                  w_cut;
    logic                  w_flash_entry;
    logic                  w_green_entry;
    logic [3*NUM_PHASES-1:0] w_light;
    assign w_phase_nxt   = (r_phase == LAST_PH) ? '0 : r_phase + PW'(1);
    assign w_phase_oh    = NUM_PHASES'(1) << r_phase;
    assign w_nxt_oh      = NUM_PHASES'(1) << w_phase_nxt;
    // a request on the green phase itself never cuts its own green
    assign w_cut         = (r_cnt >= MIN_LAST) && |(w_pend & ~w_phase_oh);
    assign w_flash_entry = bus.en && bus.flash_mode;
    assign w_green_entry = bus.en && !bus.flash_mode && r_state == ALLRED && r_cnt == AR_LAST;
    ped_req_latch #(.N(NUM_PHASES)) u_ped_latch (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (bus.ped_req),
        .i_ignore (r_state == FLASH),
        .i_clr    (w_green_entry ? w_nxt_oh : '0),
        .i_clr_all(w_flash_entry),
        .o_pend   (w_pend)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ALLRED;
            r_cnt       <= '0;
            r_phase     <= LAST_PH;
            r_flash_off <= 1'b0;
            r_walk      <= '0;
        end else if (bus.en) begin
            if (bus.flash_mode && r_state != FLASH) begin
                r_state     <= FLASH;
                r_cnt       <= '0;
                r_flash_off <= 1'b0;
            end else begin
                case (r_state)
                    ALLRED: begin
                        r_cnt <= (r_cnt == AR_LAST) ? '0 : r_cnt + CNT_W'(1);
                        if (r_cnt == AR_LAST) begin
                            r_state <= GREEN;
                            r_phase <= w_phase_nxt;
                            r_walk  <= w_pend & w_nxt_oh;
                        end
                    end
                    GREEN: begin
                        r_cnt   <= (r_cnt == G_LAST || w_cut) ? '0 : r_cnt + CNT_W'(1);
                        r_state <= (r_cnt == G_LAST || w_cut) ? YELLOW : GREEN;
                    end
                    YELLOW: begin
                        r_cnt   <= (r_cnt == Y_LAST) ? '0 : r_cnt + CNT_W'(1);
                        r_state <= (r_cnt == Y_LAST) ? ALLRED : YELLOW;
                    end
                    FLASH: begin
                        if (!bus.flash_mode) begin
                            r_state <= ALLRED;
                            r_cnt   <= '0;
                            r_phase <= LAST_PH;
                        end else if (r_cnt == F_LAST) begin
                            r_cnt       <= '0;
                            r_flash_off <= ~r_flash_off;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= ALLRED;
                endcase
            end
        end
    end
    always_comb begin
        w_light = '0;
        for (int i = 0; i < NUM_PHASES; i++)
            w_light[3*i +: 3] = (r_state == FLASH) ? (r_flash_off ? LIGHT_OFF : LIGHT_YELLOW) :
                                (PW'(i) != r_phase) ? LIGHT_RED :
                                (r_state == GREEN)  ? LIGHT_GREEN :
                                (r_state == YELLOW) ? LIGHT_YELLOW : LIGHT_RED;
    end
    assign bus.light       = w_light;
    assign bus.walk        = (r_state == GREEN) ? r_walk : '0;
    assign bus.ped_pending = w_pend;
    assign bus.cur_phase   = r_phase;
    assign bus.flashing    = (r_state == FLASH);
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised multi-phase traffic-light controller for N conflicting approaches, served round-robin. It adds an all-red clearance interval, latched pedestrian requests with walk outputs, and early green termination on a cross request once minimum green has elapsed. It also adds a maintenance flashing-yellow mode and a clock-enable hold. It is the standard signal-head controller instantiated per intersection in the verification examples.

Parameters:
NUM_PHASES, 2, number of approaches/phases (>=2)
CNT_W, 8, interval counter width
GREEN_TIME, 15, green duration in enabled cycles (>=1)
YELLOW_TIME, 5, yellow duration in enabled cycles (>=1)
ALLRED_TIME, 2, all-red clearance duration (>=1)
MIN_GREEN, 5, minimum green before a cross request may cut green (1..GREEN_TIME)
FLASH_HALF, 4, half-period of flashing yellow, in cycles (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  advance enable; low freezes state, counter and phase
flash_mode  in  1  level; high requests flashing-yellow maintenance mode
ped_req  in  NUM_PHASES  pedestrian request pulses, one bit per phase
light  out  3*NUM_PHASES  per-phase head; light[3i+2:3i]; 100=red, 010=green, 001=yellow, 000=off
walk  out  NUM_PHASES  walk indication per phase
ped_pending  out  NUM_PHASES  latched, unserved pedestrian requests
cur_phase  out  $clog2(NUM_PHASES)  phase currently or most recently green
flashing  out  1  high while in FLASH

Behaviour:
- States: ALLRED, GREEN, YELLOW, FLASH. The counter resets to 0 on every state entry.
- A state with duration T occupies exactly T enabled cycles. The counter runs 0..T-1, and the exit transition happens on the edge where counter==T-1.
- Reset (async, while rst_n low): state=ALLRED, counter=0, cur_phase=NUM_PHASES-1, ped_pending=0. Outputs: light all 100, walk=0, flashing=0.
- Outputs are combinational decodes of registered state. They change only on clk edges or on reset assertion.
- ALLRED: all heads red. On exit, cur_phase <= (cur_phase+1) mod NUM_PHASES and the next state is GREEN. The first green after reset is therefore phase 0.
- GREEN: head cur_phase = 010; all others 100.
- GREEN exit to YELLOW occurs at counter==GREEN_TIME-1, or earlier when both of these hold:
  - counter >= MIN_GREEN-1
  - ped_pending has any bit set other than cur_phase.
- YELLOW: head cur_phase = 001; others 100. Exits to ALLRED.
- ped_pending: bit i is set on any cycle where ped_req[i]=1, regardless of en or state, except in FLASH.
- On GREEN entry for phase p:
  - walk[p] takes the pre-clear value of ped_pending[p] and holds it for the whole GREEN.
  - ped_pending[p] is cleared; the clear wins over a simultaneous ped_req[p].
  - walk is 0 in every other state.
- A request for the currently green phase stays pending and never causes early termination.
- FLASH:
  - If en=1 and flash_mode=1 when sampled, the next state is FLASH from any state, and counter=0.
  - All heads show 001 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating.
  - ped_req is ignored and ped_pending is cleared on entry. walk=0, flashing=1.
  - When flash_mode is sampled low: next state ALLRED, cur_phase <= NUM_PHASES-1, so green resumes at phase 0.
- en=0: state, counter and cur_phase hold, and flash_mode is ignored. ped_pending still accumulates.
- Counter arithmetic is unsigned CNT_W bits and never wraps. Elaboration must fail if any *_TIME or FLASH_HALF exceeds 2^CNT_W - 1, or if MIN_GREEN > GREEN_TIME.

Decomposition:
- Package traffic_pkg: state enum (ALLRED, GREEN, YELLOW, FLASH) and 3-bit head constants LIGHT_RED, LIGHT_GREEN, LIGHT_YELLOW, LIGHT_OFF.
- One sub-module, ped_req_latch (NUM_PHASES wide). It provides set-on-request, clear-on-serve with clear priority, and clear-all on flash entry.
- The controller FSM, counter and light decode live in traffic_phase_ctrl.

Test Plan:
1. Defaults; release rst_n, en=1, no requests. Required sequence, with light shown as {p1,p0}:
   - 100_100 for 2 cycles
   - 100_010 for 15 cycles
   - 100_001 for 5 cycles
   - 100_100 for 2 cycles
   - 010_100 (cur_phase=1) for 15 cycles
2. Single-cycle ped_req=2'b10 while phase 0 green at counter=3. Required response:
   - phase 0 green lasts 5 cycles total, then 5 yellow and 2 all-red
   - phase 1 green with walk=2'b10 for all 15 cycles
   - ped_pending returns to 0 on that green's entry
3. ped_req=2'b01 during phase 0 green at counter=2. Required response:
   - green runs the full 15 cycles and walk[0] stays 0
   - ped_pending=2'b01 persists through phase 1 service
   - walk[0]=1 on the next phase 0 green
4. flash_mode=1 mid-green. Required response:
   - next cycle flashing=1, light=001_001 for 4 cycles, then 000_000 for 4 cycles, repeating
   - ped_req is ignored
   - drop flash_mode: 2 cycles 100_100, then 100_010 (phase 0)
5. en=0 for 10 cycles at GREEN counter=7. Required response:
   - light is held and ped_req is still latched
   - green totals 15 enabled cycles
   - if any bit other than cur_phase was latched, green ends early on the first enabled cycle
6. Assert rst_n=0 mid-YELLOW between clock edges. Required response:
   - light goes to 100_100 immediately, and walk, ped_pending and flashing go to 0
   - after release, the scenario 1 sequence repeats exactly
